neo_sample_sequencer: RTL

Sequencing controller for the NEO sample memory (N-bit signed, M locations, registered read, no write enable). It accepts input samples over a valid/ready handshake and stores them in the memory as a circular buffer. For each new sample it reads back the three most recent samples and presents them as an aligned triplet (x[n-1], x[n], x[n+1]) to the downstream NEO arithmetic stage. It is the only master of the memory's write and read address/data ports.

---
 rtl/neo_sample_sequencer.sv | 89 ++++++++
 1 files changed

// File: rtl/neo_sample_sequencer.sv
// neo_sample_sequencer: stores samples in a circular buffer and replays the three newest as a (x[n-1], x[n], x[n+1]) triplet.
// Define NEO_SEQ_BYPASS_EN to take x[n+1] straight from the write register and skip the third memory read.
module neo_sample_sequencer #(
  parameter int N = 8,
  parameter int M = 16
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [N-1:0]      in_data,
  output logic [$clog2(M)-1:0]     mem_waddr,
  output logic signed [N-1:0]      mem_wdata,
  output logic [$clog2(M)-1:0]     mem_raddr,
  input  logic signed [N-1:0]      mem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [N-1:0]      out_prev,
  output logic signed [N-1:0]      out_cur,
  output logic signed [N-1:0]      out_next,
  output logic                     primed
);
  localparam int AW = $clog2(M);
  typedef enum logic [2:0] {IDLE, WR, RA, RB, RC, RD, OUT} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] wptr, w;
  logic [1:0] fill;
  assign in_ready = reset && (state == IDLE);
  assign primed = (fill == 2'd3);
  always_ff @(posedge Clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = in_valid ? WR : IDLE;
      WR: state_nxt = primed ? RA : IDLE;
      RA: state_nxt = RB;
      RB: state_nxt = RC;
`ifdef NEO_SEQ_BYPASS_EN
      RC: state_nxt = OUT;
`else
      RC: state_nxt = RD;
      RD: state_nxt = OUT;
`endif
      OUT: state_nxt = out_ready ? IDLE : OUT;
      default: state_nxt = IDLE;
    endcase
  end
  // Write pair only moves on an accept, so idle cycles rewrite the same location harmlessly.
  always_ff @(posedge Clk or negedge reset)
    if (!reset) begin
      wptr <= '0;
      w <= '0;
      fill <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_raddr <= '0;
      out_prev <= '0;
      out_cur <= '0;
      out_next <= '0;
      out_valid <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        mem_waddr <= wptr;
        mem_wdata <= in_data;
        w <= wptr;
        wptr <= wptr + AW'(1);
        fill <= primed ? fill : fill + 2'd1;
      end
      if (state == WR && primed) mem_raddr <= w - AW'(2);
      if (state == RA) mem_raddr <= w - AW'(1);
      if (state == RB) out_prev <= mem_rdata;
      if (state == RC) out_cur <= mem_rdata;
`ifdef NEO_SEQ_BYPASS_EN
      if (state == RC) begin
        out_next <= mem_wdata;
        out_valid <= 1'b1;
      end
`else
      if (state == RB) mem_raddr <= w;
      if (state == RD) begin
        out_next <= mem_rdata;
        out_valid <= 1'b1;
      end
`endif
      if (state == OUT && out_ready) out_valid <= 1'b0;
    end
endmodule
